instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the immediate/displacement shifter-sign-extender.
- Owns PC/nPC, issues word reads to instruction memory over the MOV/MFC handshake, and latches the returned word into IR, which drives the extender's IR31_0 input.
- Consumes the extender's 32-bit output (Disp) to redirect nPC on taken branches and calls, with SPARC-style delay slot and annul.

---
 rtl/instruction_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC/nPC, reads instruction words over the
// MOV/MFC handshake, holds them in IR for the control unit and redirects
// nPC with SPARC-style delay slot and annul semantics.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MFC_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFC,
    input  logic [31:0] MemData,
    input  logic        Advance,
    input  logic        Redirect,
    input  logic        Call,
    input  logic        Annul,
    input  logic [31:0] Disp,
    output logic        MOV,
    output logic [31:0] MemAddr,
    output logic [31:0] IR,
    output logic        IRValid,
    output logic [31:0] PC,
    output logic [31:0] nPC,
    output logic        FetchFault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Counter value seen during the last FETCH cycle allowed before a fault.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MFC_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic [7:0]  r_cnt;
    logic        r_mov;
    logic        r_fault;

    logic [31:0] w_pc_next;
    logic [31:0] w_npc_next;
    logic [31:0] w_ir_next;
    logic        w_ir_valid_next;
    logic [7:0]  w_cnt_next;
    logic        w_mov_next;
    logic        w_fault_next;
    logic        w_take_word;
    logic        w_advance;

    // Word-align a computed fetch target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    assign w_take_word = (r_state == ST_FETCH) && MFC;
    assign w_advance   = (r_state == ST_HOLD) && Advance;

    // State register plus all datapath/output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_npc      <= RESET_PC + 32'd4;
            r_ir       <= 32'd0;
            r_ir_valid <= 1'b0;
            r_cnt      <= 8'd0;
            r_mov      <= 1'b1;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_pc_next;
            r_npc      <= w_npc_next;
            r_ir       <= w_ir_next;
            r_ir_valid <= w_ir_valid_next;
            r_cnt      <= w_cnt_next;
            r_mov      <= w_mov_next;
            r_fault    <= w_fault_next;
        end
    end

    // Next-state logic; MFC beats the timeout when both land on one edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (MFC) begin
                    w_next_state = ST_HOLD;
                end else if (r_cnt >= TIMEOUT_LAST) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (Advance) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_FAULT: w_next_state = ST_FETCH;
            default:  w_next_state = ST_FETCH;
        endcase
    end

    // PC/nPC, IR and timeout counter updates.
    always_comb begin
        w_pc_next       = r_pc;
        w_npc_next      = r_npc;
        w_ir_next       = r_ir;
        w_ir_valid_next = r_ir_valid;
        w_cnt_next      = 8'd0;

        if (w_take_word) begin
            w_ir_next       = MemData;
            w_ir_valid_next = 1'b1;
        end else if (w_advance) begin
            w_ir_valid_next = 1'b0;
        end else begin
            w_ir_valid_next = r_ir_valid;
        end

        if (r_state == ST_FETCH && !MFC && r_cnt < TIMEOUT_LAST) begin
            w_cnt_next = r_cnt + 8'd1;
        end else begin
            w_cnt_next = 8'd0;
        end

        // Annul only matters for an untaken branch; a taken one always
        // executes its delay slot.
        if (w_advance) begin
            if (Redirect && !Call) begin
                w_pc_next  = r_npc;
                w_npc_next = align_word(r_npc + Disp);
            end else if (Redirect && Call) begin
                w_pc_next  = r_npc;
                w_npc_next = align_word(r_pc + Disp);
            end else if (Annul) begin
                w_pc_next  = align_word(r_npc + 32'd4);
                w_npc_next = align_word(r_npc + 32'd8);
            end else begin
                w_pc_next  = r_npc;
                w_npc_next = align_word(r_npc + 32'd4);
            end
        end else begin
            w_pc_next  = r_pc;
            w_npc_next = r_npc;
        end
    end

    // Moore outputs computed from the next state so they come out of flops.
    always_comb begin
        w_mov_next   = 1'b0;
        w_fault_next = 1'b0;
        case (w_next_state)
            ST_FETCH: w_mov_next   = 1'b1;
            ST_HOLD:  w_mov_next   = 1'b0;
            ST_FAULT: w_fault_next = 1'b1;
            default:  w_mov_next   = 1'b1;
        endcase
    end

    assign MOV        = r_mov;
    assign MemAddr    = r_pc;
    assign IR         = r_ir;
    assign IRValid    = r_ir_valid;
    assign PC         = r_pc;
    assign nPC        = r_npc;
    assign FetchFault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// hand-written timeout/reset sequences and a randomized run against a
// transaction-level model of the fetch/advance rules.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          MFC_TIMEOUT = 15;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MFC = 1'b0;
    logic [31:0] MemData = 32'd0;
    logic        Advance = 1'b0;
    logic        Redirect = 1'b0;
    logic        Call = 1'b0;
    logic        Annul = 1'b0;
    logic [31:0] Disp = 32'd0;
    logic        MOV;
    logic [31:0] MemAddr;
    logic [31:0] IR;
    logic        IRValid;
    logic [31:0] PC;
    logic [31:0] nPC;
    logic        FetchFault;

    int n_vec = 0;
    int n_bad = 0;

    // Model of the architectural state.
    logic [31:0] m_pc;
    logic [31:0] m_npc;
    logic [31:0] m_ir;

    typedef struct {
        logic        rst;
        int unsigned wait_n;
        logic [31:0] data;
        logic        redirect;
        logic        call;
        logic        annul;
        logic [31:0] disp;
        logic [31:0] exp_pc;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t tbl[20];

    instruction_fetch_unit #(
        .RESET_PC(RESET_PC),
        .MFC_TIMEOUT(MFC_TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .MFC(MFC), .MemData(MemData),
        .Advance(Advance), .Redirect(Redirect), .Call(Call), .Annul(Annul),
        .Disp(Disp), .MOV(MOV), .MemAddr(MemAddr), .IR(IR), .IRValid(IRValid),
        .PC(PC), .nPC(nPC), .FetchFault(FetchFault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Successor addresses after the control unit releases an instruction.
    function automatic logic [63:0] model_adv(input logic [31:0] pc, input logic [31:0] npc,
                                              input logic [31:0] disp, input logic r,
                                              input logic c, input logic a);
        logic [31:0] np;
        logic [31:0] nn;
        if (r) begin
            np = npc;
            nn = (c ? pc : npc) + disp;
        end else if (a) begin
            np = npc + 32'd4;
            nn = npc + 32'd8;
        end else begin
            np = npc;
            nn = npc + 32'd4;
        end
        return {np & 32'hFFFF_FFFC, nn & 32'hFFFF_FFFC};
    endfunction

    task automatic drive_noise(input bit en);
        if (en) begin
            Advance  = 1'($urandom);
            Redirect = 1'($urandom);
            Call     = 1'($urandom);
            Annul    = 1'($urandom);
            Disp     = $urandom;
        end else begin
            Advance  = 1'b0;
            Redirect = 1'b0;
            Call     = 1'b0;
            Annul    = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset   = 1'b1;
        MFC     = 1'b1;
        MemData = $urandom | 32'h1;
        drive_noise(1'b1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        MFC   = 1'b0;
        drive_noise(1'b0);
        m_pc  = RESET_PC;
        m_npc = RESET_PC + 32'd4;
        m_ir  = 32'd0;
        chk("rst_pc", PC, m_pc);
        chk("rst_npc", nPC, m_npc);
        chk("rst_ir", IR, 32'd0);
        chk("rst_irvalid", 32'(IRValid), 32'd0);
        chk("rst_mov", 32'(MOV), 32'd1);
        chk("rst_fault", 32'(FetchFault), 32'd0);
    endtask

    // wait_n cycles with MFC low, then MFC high with data.
    task automatic fetch(input int unsigned wait_n, input logic [31:0] data, input bit noise);
        for (int i = 0; i < int'(wait_n); i++) begin
            @(negedge Clk);
            MFC     = 1'b0;
            MemData = $urandom;
            drive_noise(noise);
            chk("fetch_wait_mov", 32'(MOV), 32'd1);
            chk("fetch_wait_addr", MemAddr, m_pc);
            chk("fetch_wait_fault", 32'(FetchFault), 32'd0);
            @(posedge Clk);
        end
        @(negedge Clk);
        MFC     = 1'b1;
        MemData = data;
        drive_noise(noise);
        chk("fetch_mov", 32'(MOV), 32'd1);
        chk("fetch_addr", MemAddr, m_pc);
        @(posedge Clk);
        #1;
        MFC     = 1'b0;
        MemData = $urandom;
        drive_noise(1'b0);
        m_ir = data;
        chk("fetch_ir", IR, m_ir);
        chk("fetch_irvalid", 32'(IRValid), 32'd1);
        chk("fetch_mov_off", 32'(MOV), 32'd0);
        chk("fetch_fault", 32'(FetchFault), 32'd0);
        chk("fetch_pc", PC, m_pc);
        chk("fetch_npc", nPC, m_npc);
    endtask

    task automatic hold(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            @(negedge Clk);
            Advance  = 1'b0;
            Redirect = 1'($urandom);
            Annul    = 1'($urandom);
            MFC      = 1'($urandom);
            MemData  = $urandom;
            @(posedge Clk);
            #1;
            MFC = 1'b0;
            chk("hold_ir", IR, m_ir);
            chk("hold_irvalid", 32'(IRValid), 32'd1);
            chk("hold_mov", 32'(MOV), 32'd0);
            chk("hold_pc", PC, m_pc);
        end
    endtask

    task automatic advance(input logic r, input logic c, input logic a, input logic [31:0] d,
                           input logic [31:0] exp_pc, input logic [31:0] exp_npc);
        @(negedge Clk);
        Advance  = 1'b1;
        Redirect = r;
        Call     = c;
        Annul    = a;
        Disp     = d;
        MFC      = 1'($urandom);
        MemData  = $urandom;
        @(posedge Clk);
        #1;
        drive_noise(1'b0);
        MFC = 1'b0;
        chk("adv_pc", PC, exp_pc);
        chk("adv_npc", nPC, exp_npc);
        chk("adv_addr", MemAddr, exp_pc);
        chk("adv_irvalid", 32'(IRValid), 32'd0);
        chk("adv_mov", 32'(MOV), 32'd1);
        chk("adv_ir_kept", IR, m_ir);
        m_pc  = exp_pc;
        m_npc = exp_npc;
    endtask

    task automatic timeout_seq();
        for (int i = 0; i < MFC_TIMEOUT; i++) begin
            @(negedge Clk);
            MFC = 1'b0;
            drive_noise(1'b1);
            chk("to_wait_mov", 32'(MOV), 32'd1);
            chk("to_wait_fault", 32'(FetchFault), 32'd0);
            @(posedge Clk);
        end
        #1;
        drive_noise(1'b0);
        chk("to_fault", 32'(FetchFault), 32'd1);
        chk("to_fault_mov", 32'(MOV), 32'd0);
        chk("to_fault_pc", PC, m_pc);
        @(posedge Clk);
        #1;
        chk("to_retry_fault", 32'(FetchFault), 32'd0);
        chk("to_retry_mov", 32'(MOV), 32'd1);
        chk("to_retry_addr", MemAddr, m_pc);
        chk("to_retry_irvalid", 32'(IRValid), 32'd0);
    endtask

    initial begin
        logic [63:0] nx;
        logic        r;
        logic        c;
        logic        a;
        logic [31:0] d;
        int unsigned sel;

        tbl[0]  = '{1'b1, 2, 32'h8210_2005, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h8};
        tbl[1]  = '{1'b0, 0, 32'h0100_0000, 1'b1, 1'b0, 1'b0, 32'hC,         32'h8,         32'h14};
        tbl[2]  = '{1'b1, 1, 32'h9DE3_BFA0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h8};
        tbl[3]  = '{1'b0, 0, 32'h4000_0010, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'hC};
        tbl[4]  = '{1'b0, 3, 32'h4000_0011, 1'b1, 1'b1, 1'b0, 32'h40,        32'hC,         32'h48};
        tbl[5]  = '{1'b0, 0, 32'h1080_0002, 1'b1, 1'b0, 1'b0, 32'hB8,        32'h48,        32'h100};
        tbl[6]  = '{1'b0, 1, 32'h1280_0003, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFEC, 32'h100,       32'hEC};
        tbl[7]  = '{1'b0, 0, 32'h1080_0004, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF24, 32'hEC,        32'h10};
        tbl[8]  = '{1'b0, 0, 32'hA010_0001, 1'b0, 1'b0, 1'b0, 32'h0,         32'h10,        32'h14};
        tbl[9]  = '{1'b0, 2, 32'h2280_0005, 1'b0, 1'b0, 1'b1, 32'h0,         32'h18,        32'h1C};
        tbl[10] = '{1'b1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h8};
        tbl[11] = '{1'b0, 0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'hC};
        tbl[12] = '{1'b0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h10};
        tbl[13] = '{1'b0, 0, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, 32'h0,         32'h10,        32'h14};
        tbl[14] = '{1'b0, 1, 32'h3080_0006, 1'b1, 1'b0, 1'b1, 32'h8,         32'h14,        32'h1C};
        tbl[15] = '{1'b0, 0, 32'h1080_0007, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h1C,        32'hFFFF_FFFC};
        tbl[16] = '{1'b0, 0, 32'h0123_4567, 1'b0, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0};
        tbl[17] = '{1'b0, 4, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h4};
        tbl[18] = '{1'b0, 0, 32'h2280_0008, 1'b0, 1'b1, 1'b1, 32'h40,        32'h8,         32'hC};
        tbl[19] = '{1'b0, 0, 32'h1080_0009, 1'b1, 1'b0, 1'b0, 32'h13,        32'hC,         32'h1C};

        m_pc  = RESET_PC;
        m_npc = RESET_PC + 32'd4;
        m_ir  = 32'd0;

        // Directed vector table.
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end
            fetch(tbl[i].wait_n, tbl[i].data, 1'b0);
            advance(tbl[i].redirect, tbl[i].call, tbl[i].annul, tbl[i].disp,
                    tbl[i].exp_pc, tbl[i].exp_npc);
        end

        // Timeout with retry at the same address, then MFC on the timeout cycle.
        do_reset();
        timeout_seq();
        fetch(MFC_TIMEOUT - 1, 32'hC0FF_EE00, 1'b0);
        @(negedge Clk);
        chk("to_edge_nofault", 32'(FetchFault), 32'd0);
        chk("to_edge_hold_mov", 32'(MOV), 32'd0);
        advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 32'h8);

        // Reset while a fetch is outstanding; MFC in the reset cycle is dropped.
        fetch(1, 32'h1234_5678, 1'b0);
        advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 32'hC);
        do_reset();
        @(negedge Clk);
        chk("post_rst_irvalid", 32'(IRValid), 32'd0);
        chk("post_rst_addr", MemAddr, RESET_PC);

        // Randomized run against the model.
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                do_reset();
            end else if (sel == 1) begin
                timeout_seq();
            end
            fetch($urandom_range(0, MFC_TIMEOUT - 1), $urandom, 1'b1);
            hold($urandom_range(0, 3));
            if (sel == 2) begin
                do_reset();
            end else begin
                r  = 1'($urandom);
                c  = 1'($urandom);
                a  = 1'($urandom);
                d  = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000_01FF);
                nx = model_adv(m_pc, m_npc, d, r, c, a);
                advance(r, c, a, d, nx[63:32], nx[31:0]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
